ce_requant: RTL and testbench

Requantization and output-buffer stage sitting directly downstream of the convolution element (CE). It takes the wide accumulated CE result (`d_out`/`en_out`), applies rounded right shift, optional ReLU and saturation back to the N-bit data width, and buffers results in a small FIFO behind a valid/ready port toward the next layer's line buffer. CE has no backpressure, so overflow is detected, flagged and counted rather than stalled.

---
 rtl/ce_requant_pkg.sv | 47 ++++
 rtl/ce_out_fifo.sv | 58 +++++
 rtl/ce_requant.sv | 129 ++++++++++++
 tb/tb_ce_requant.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_requant_pkg.sv
// Shared CE-side requantization helpers: output width derivation,
// round-half-up arithmetic shift, and clip limits per output mode.
package ce_requant_pkg;

  // Wide enough that the rounding add on any CE result cannot wrap.
  localparam int CE_CALC_W = 64;

  typedef logic signed [CE_CALC_W-1:0] ce_calc_t;

  // CE accumulator output width for N-bit data and M-bit weights.
  function automatic int ce_dw(input int n, input int m);
    return n + m + 15;
  endfunction

  // Arithmetic right shift with round-half-up (toward +inf).
  function automatic ce_calc_t ce_round_shift(input ce_calc_t x, input int sr);
    if (sr <= 0) return x;
    return (x + (ce_calc_t'(1) <<< (sr - 1))) >>> sr;
  endfunction

  // Largest representable output value.
  function automatic ce_calc_t ce_max(input int n, input logic relu);
    if (relu) return (ce_calc_t'(1) <<< n) - ce_calc_t'(1);
    return (ce_calc_t'(1) <<< (n - 1)) - ce_calc_t'(1);
  endfunction

  // Smallest representable output value.
  function automatic ce_calc_t ce_min(input int n, input logic relu);
    if (relu) return '0;
    return -(ce_calc_t'(1) <<< (n - 1));
  endfunction

  // ReLU zeroing followed by saturation to the output range.
  function automatic ce_calc_t ce_clip(input ce_calc_t r, input int n, input logic relu);
    if (relu && (r < 0)) return '0;
    if (r > ce_max(n, relu)) return ce_max(n, relu);
    if (r < ce_min(n, relu)) return ce_min(n, relu);
    return r;
  endfunction

  // True when saturation altered the value; ReLU zeroing does not count.
  function automatic logic ce_is_clipped(input ce_calc_t r, input int n, input logic relu);
    if (relu && (r < 0)) return 1'b0;
    return (r > ce_max(n, relu)) || (r < ce_min(n, relu));
  endfunction

endpackage

// File: rtl/ce_out_fifo.sv
// Synchronous FIFO holding requantized results. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module ce_out_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; emptiness is tracked by r_count and
  // the consumer never sees a slot that was not written first.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ce_requant.sv
// Requantizes wide CE results (rounded shift, optional ReLU, saturation)
// and buffers them behind a valid/ready port. The CE cannot be stalled, so
// results arriving at a full buffer are dropped and counted.
module ce_requant
  import ce_requant_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int SR    = 2,
  parameter int RELU  = 1,
  parameter int DEPTH = 4,
  parameter int FRAME = 16,
  localparam int DW   = ce_dw(N, M)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] d_in,
  input  logic                 en_in,
  output logic [N-1:0]         q_data,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic                 q_last,
  output logic                 sat,
  output logic                 ovf,
  output logic [7:0]           drop_cnt,
  input  logic                 clr
);

  localparam int   S1_W    = DW + 1;
  localparam logic RELU_EN = (RELU != 0);
  localparam int   FCW     = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [FCW-1:0] LAST_CNT = FCW'(FRAME - 1);

  logic                   r_s1_valid;
  logic signed [S1_W-1:0] r_s1_data;
  logic                   r_s2_valid;
  logic [N-1:0]           r_s2_data;
  logic                   r_s2_clip;
  logic [FCW-1:0]         r_frame_cnt;
  logic                   r_sat;
  logic                   r_ovf;
  logic [7:0]             r_drop_cnt;

  logic [N-1:0]           w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_drop;

  // S1: rounded shift of the incoming CE result, kept one bit wider than
  // the input so the rounding term never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= en_in;
      if (en_in) r_s1_data <= S1_W'(ce_round_shift(ce_calc_t'(d_in), SR));
    end
  end

  // S2: ReLU and saturation to the N-bit output range, remembering clips.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_clip  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= N'(ce_clip(ce_calc_t'(r_s1_data), N, RELU_EN));
        r_s2_clip <= ce_is_clipped(ce_calc_t'(r_s1_data), N, RELU_EN);
      end
    end
  end

  ce_out_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_s2_valid),
    .i_pop   (w_pop),
    .i_data  (r_s2_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign q_valid  = ~w_empty;
  assign w_pop    = q_valid & q_ready;
  assign w_drop   = r_s2_valid & w_full & ~w_pop;
  // Head is masked while empty so the port reads zero out of reset.
  assign q_data   = q_valid ? w_head : '0;
  assign q_last   = q_valid & (r_frame_cnt == LAST_CNT);
  assign sat      = r_sat;
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

  // Frame position of the head word; wraps on the pop that carries q_last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (w_pop) begin
      r_frame_cnt <= q_last ? '0 : r_frame_cnt + 1'b1;
    end
  end

  // Sticky clip/overflow flags and saturating drop counter; a new event in
  // the same cycle as clr takes precedence over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat      <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_sat <= (r_sat & ~clr) | (r_s2_valid & r_s2_clip);
      r_ovf <= (r_ovf & ~clr) | w_drop;
      if (w_drop) begin
        if (clr)                       r_drop_cnt <= 8'd1;
        else if (r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (clr) begin
        r_drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ce_requant.sv
// Directed bench for ce_requant: one unsigned/ReLU instance (FRAME=3) and
// one signed instance share the same stimulus.
module tb_ce_requant;

  localparam int DW = 23;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] d_in;
  logic                 en_in;
  logic                 q_ready;
  logic                 clr;

  logic [3:0] q_data_a, q_data_b;
  logic       q_valid_a, q_valid_b;
  logic       q_last_a, q_last_b;
  logic       sat_a, sat_b;
  logic       ovf_a, ovf_b;
  logic [7:0] drop_cnt_a, drop_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ce_requant #(
    .N(4), .M(4), .SR(2), .RELU(1), .DEPTH(4), .FRAME(3)
  ) u_dut_a (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
    .q_data(q_data_a), .q_valid(q_valid_a), .q_ready(q_ready),
    .q_last(q_last_a), .sat(sat_a), .ovf(ovf_a),
    .drop_cnt(drop_cnt_a), .clr(clr)
  );

  ce_requant #(
    .N(4), .M(4), .SR(2), .RELU(0), .DEPTH(4), .FRAME(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
    .q_data(q_data_b), .q_valid(q_valid_b), .q_ready(q_ready),
    .q_last(q_last_b), .sat(sat_b), .ovf(ovf_b),
    .drop_cnt(drop_cnt_b), .clr(clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one CE result and wait until it reaches the FIFO head.
  task automatic send(input int d);
    d_in  = DW'(d);
    en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop1();
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; d_in = '0; en_in = 1'b0; q_ready = 1'b0; clr = 1'b0;
    tick();
    tick();
    check("rst_q_valid",  32'(q_valid_a),  32'd0);
    check("rst_q_data",   32'(q_data_a),   32'd0);
    check("rst_q_last",   32'(q_last_a),   32'd0);
    check("rst_sat",      32'(sat_a),      32'd0);
    check("rst_ovf",      32'(ovf_a),      32'd0);
    check("rst_drop_cnt", 32'(drop_cnt_a), 32'd0);
    rst = 1'b1;
    tick();

    // 22 -> (22+2)>>2 = 6, valid three edges after the input edge.
    d_in = DW'(22); en_in = 1'b1;
    tick();
    en_in = 1'b0;
    check("lat_edge0", 32'(q_valid_a), 32'd0);
    tick();
    check("lat_edge1", 32'(q_valid_a), 32'd0);
    tick();
    check("lat_edge2", 32'(q_valid_a), 32'd1);
    check("d22_a",     32'(q_data_a),  32'd6);
    check("d22_b",     32'(q_data_b),  32'd6);
    check("d22_sat",   32'(sat_a),     32'd0);
    pop1();
    check("d22_popped", 32'(q_valid_a), 32'd0);

    // -5 -> -1: ReLU zero (no clip), signed 4'hF.
    send(-5);
    check("m5_a",     32'(q_data_a), 32'd0);
    check("m5_sat_a", 32'(sat_a),    32'd0);
    check("m5_b",     32'(q_data_b), 32'hF);
    check("m5_sat_b", 32'(sat_b),    32'd0);
    pop1();

    // 100 -> 25: clipped to 15 unsigned, 7 signed.
    send(100);
    check("d100_a",     32'(q_data_a), 32'hF);
    check("d100_sat_a", 32'(sat_a),    32'd1);
    check("d100_b",     32'(q_data_b), 32'h7);
    check("d100_sat_b", 32'(sat_b),    32'd1);
    pop1();
    clr_pulse();
    check("clr_sat_a", 32'(sat_a), 32'd0);
    check("clr_sat_b", 32'(sat_b), 32'd0);

    // -37 -> -9: signed clip to 4'b1000, ReLU zero without clip.
    send(-37);
    check("m37_b",     32'(q_data_b), 32'h8);
    check("m37_sat_b", 32'(sat_b),    32'd1);
    check("m37_a",     32'(q_data_a), 32'd0);
    check("m37_sat_a", 32'(sat_a),    32'd0);
    pop1();
    clr_pulse();

    // 26 -> 7: in range for both modes.
    send(26);
    check("d26_b",     32'(q_data_b), 32'h7);
    check("d26_sat_b", 32'(sat_b),    32'd0);
    check("d26_a",     32'(q_data_a), 32'h7);
    pop1();

    // Clip event in the same cycle as clr: the flag stays set.
    d_in = DW'(100); en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_vs_clip", 32'(sat_a), 32'd1);
    pop1();
    clr_pulse();

    // Overflow: six back-to-back results into a 4-deep FIFO with no reader.
    for (int k = 1; k <= 6; k++) begin
      d_in = DW'(4 * k); en_in = 1'b1;
      tick();
    end
    en_in = 1'b0;
    tick();
    check("ovf_first_drop", 32'(drop_cnt_a), 32'd1);
    check("ovf_flag",       32'(ovf_a),      32'd1);
    tick();
    check("ovf_drop_cnt", 32'(drop_cnt_a), 32'd2);
    check("ovf_head",     32'(q_data_a),   32'd1);

    // Full FIFO: a pop in the same cycle as the push lets the push through.
    d_in = DW'(36); en_in = 1'b1;
    tick();
    en_in = 1'b0;
    tick();
    check("fpp_head_before", 32'(q_data_a), 32'd1);
    q_ready = 1'b1;
    tick();
    check("fpp_no_drop", 32'(drop_cnt_a), 32'd2);
    check("fpp_pop2",    32'(q_data_a),   32'd2);
    tick();
    check("fpp_pop3", 32'(q_data_a), 32'd3);
    tick();
    check("fpp_pop4", 32'(q_data_a), 32'd4);
    tick();
    check("fpp_pop9", 32'(q_data_a), 32'd9);
    tick();
    check("fpp_empty", 32'(q_valid_a), 32'd0);
    q_ready = 1'b0;

    // Reset with three entries queued and both pipeline stages busy.
    for (int k = 0; k < 5; k++) begin
      d_in = (k == 0) ? DW'(100) : DW'(4 * k); en_in = 1'b1;
      tick();
    end
    en_in = 1'b0;
    check("pre_rst_valid", 32'(q_valid_a), 32'd1);
    check("pre_rst_sat",   32'(sat_a),     32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_q_valid",  32'(q_valid_a),  32'd0);
    check("mid_rst_q_data",   32'(q_data_a),   32'd0);
    check("mid_rst_q_last",   32'(q_last_a),   32'd0);
    check("mid_rst_sat",      32'(sat_a),      32'd0);
    check("mid_rst_ovf",      32'(ovf_a),      32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt_a), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_no_stale", 32'(q_valid_a), 32'd0);

    // Seven streamed results with the reader always ready: q_last on the
    // third and sixth pop of the restarted frame count.
    q_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      en_in = (c < 7);
      d_in  = DW'(4 * (c + 1));
      tick();
      if (c == 1) check("stream_lat", 32'(q_valid_a), 32'd0);
      if (c >= 2 && c <= 8) begin
        check($sformatf("stream_valid_%0d", c - 2), 32'(q_valid_a), 32'd1);
        check($sformatf("stream_data_%0d", c - 2),  32'(q_data_a),  32'(c - 1));
        check($sformatf("stream_last_%0d", c - 2),  32'(q_last_a),
              ((c - 2) == 2 || (c - 2) == 5) ? 32'd1 : 32'd0);
      end
      if (c == 9) check("stream_drained", 32'(q_valid_a), 32'd0);
    end
    en_in   = 1'b0;
    q_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
